// File: rtl/my_slave_rdy_responder_if.sv
// Request/acknowledge pair of the slave 4-phase handshake.
// The master raises async_en; the slave answers with async_rdy.
interface my_slave_rdy_responder_if;
   logic async_en;
   logic async_rdy;

   modport master (
      output async_en,
      input  async_rdy
   );

   modport slave (
      input  async_en,
      output async_rdy
   );
endinterface

// File: rtl/my_slave_rdy_responder.sv
// Slave-side responder: synchronizes async_en, inserts wait states with back-pressure,
// acknowledges with async_rdy, counts completed handshakes and flags stuck requests.
module my_slave_rdy_responder #(
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned WAIT_CYCLES    = 4,
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter int unsigned CNT_W          = 16
) (
   input  logic                            i_clk,
   input  logic                            i_rst,
   my_slave_rdy_responder_if.slave         if_slave,
   input  logic                            i_hold_off,
   input  logic                            i_clr_err,
   output logic                            o_busy,
   output logic [CNT_W-1:0]                o_txn_count,
   output logic                            o_timeout_err
);

   // Counter widths are kept at least one bit so zero-wait / single-cycle timeouts elaborate.
   localparam int unsigned WCW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam int unsigned TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StAck,
      StErr
   } state_e;

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_en_s;

   state_e                 r_state;
   state_e                 w_state_nxt;
   logic [WCW-1:0]         r_wcnt;
   logic [WCW-1:0]         w_wcnt_nxt;
   logic [TCW-1:0]         r_tcnt;
   logic [TCW-1:0]         w_tcnt_nxt;
   logic [CNT_W-1:0]       r_txn_count;
   logic [CNT_W-1:0]       w_txn_nxt;
   logic                   r_timeout_err;
   logic                   w_err_nxt;
   logic                   w_set_err;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], if_slave.async_en};
      end
   end

   assign w_en_s = r_sync[SYNC_STAGES-1];

   always_comb begin
      w_state_nxt = r_state;
      w_wcnt_nxt  = r_wcnt;
      w_tcnt_nxt  = r_tcnt;
      w_txn_nxt   = r_txn_count;
      w_set_err   = 1'b0;
      case (r_state)
         StIdle: begin
            if (w_en_s) begin
               w_state_nxt = StWait;
               w_wcnt_nxt  = WCW'(WAIT_CYCLES);
            end
         end
         StWait: begin
            if (!w_en_s) begin
               w_state_nxt = StIdle;
            end else if (i_hold_off) begin
               w_wcnt_nxt = r_wcnt;
            end else if (r_wcnt == '0) begin
               w_state_nxt = StAck;
               w_tcnt_nxt  = '0;
            end else begin
               w_wcnt_nxt = r_wcnt - WCW'(1);
            end
         end
         StAck: begin
            if (!w_en_s) begin
               w_state_nxt = StIdle;
               w_txn_nxt   = r_txn_count + CNT_W'(1);
            end else if (r_tcnt == TCW'(TIMEOUT_CYCLES - 1)) begin
               w_state_nxt = StErr;
               w_set_err   = 1'b1;
            end else begin
               w_tcnt_nxt = r_tcnt + TCW'(1);
            end
         end
         StErr: begin
            if (!w_en_s) begin
               w_state_nxt = StIdle;
            end
         end
         default: w_state_nxt = StIdle;
      endcase
      // A timeout in the same cycle as a clear must remain visible.
      w_err_nxt = w_set_err ? 1'b1 : (i_clr_err ? 1'b0 : r_timeout_err);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state       <= StIdle;
         r_wcnt        <= '0;
         r_tcnt        <= '0;
         r_txn_count   <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_wcnt        <= w_wcnt_nxt;
         r_tcnt        <= w_tcnt_nxt;
         r_txn_count   <= w_txn_nxt;
         r_timeout_err <= w_err_nxt;
      end
   end

   assign if_slave.async_rdy = (r_state == StAck);
   assign o_busy             = (r_state != StIdle);
   assign o_txn_count        = r_txn_count;
   assign o_timeout_err      = r_timeout_err;

endmodule

// File: tb/tb_my_slave_rdy_responder.sv
// Directed bench for my_slave_rdy_responder: default instance plus a CNT_W=4, zero-wait
// instance for wrap-around checks.
module tb_my_slave_rdy_responder;

   logic       clk;
   logic       rst;
   logic       hold_off;
   logic       clr_err;
   logic       busy;
   logic [15:0] txn_count;
   logic       timeout_err;

   logic       hold_off2;
   logic       clr_err2;
   logic       busy2;
   logic [3:0] txn_count2;
   logic       timeout_err2;

   int checks;
   int errors;
   logic [15:0] exp_cnt;

   my_slave_rdy_responder_if bus ();
   my_slave_rdy_responder_if bus2 ();

   my_slave_rdy_responder dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .if_slave      (bus.slave),
      .i_hold_off    (hold_off),
      .i_clr_err     (clr_err),
      .o_busy        (busy),
      .o_txn_count   (txn_count),
      .o_timeout_err (timeout_err)
   );

   my_slave_rdy_responder #(
      .SYNC_STAGES    (2),
      .WAIT_CYCLES    (0),
      .TIMEOUT_CYCLES (64),
      .CNT_W          (4)
   ) dut2 (
      .i_clk         (clk),
      .i_rst         (rst),
      .if_slave      (bus2.slave),
      .i_hold_off    (hold_off2),
      .i_clr_err     (clr_err2),
      .o_busy        (busy2),
      .o_txn_count   (txn_count2),
      .o_timeout_err (timeout_err2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance n active edges and settle 1 time unit past the last one.
   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      ticks(2);
      checks++;
      if (bus.async_rdy !== 1'b0 || busy !== 1'b0 || txn_count !== 16'd0 || timeout_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_state got rdy=%b busy=%b cnt=%0d err=%b exp all 0",
                  bus.async_rdy, busy, txn_count, timeout_err);
      end
      rst = 1'b0;
      ticks(2);
      exp_cnt = 16'd0;
   endtask

   task automatic test_basic();
      bus.async_en = 1'b1;
      ticks(7);  // after edge 6
      checks++;
      if (bus.async_rdy !== 1'b0) begin
         errors++;
         $display("FAIL basic_rdy_early got %b exp 0", bus.async_rdy);
      end
      ticks(1);  // after edge 7
      checks++;
      if (bus.async_rdy !== 1'b1) begin
         errors++;
         $display("FAIL basic_rdy_rise got %b exp 1", bus.async_rdy);
      end
      ticks(12); // after edge 19
      bus.async_en = 1'b0;
      ticks(2);  // after edge 21
      checks++;
      if (bus.async_rdy !== 1'b1) begin
         errors++;
         $display("FAIL basic_rdy_hold got %b exp 1", bus.async_rdy);
      end
      ticks(1);  // after edge 22
      exp_cnt = exp_cnt + 16'd1;
      checks++;
      if (bus.async_rdy !== 1'b0 || txn_count !== exp_cnt) begin
         errors++;
         $display("FAIL basic_release got rdy=%b cnt=%0d exp rdy=0 cnt=%0d",
                  bus.async_rdy, txn_count, exp_cnt);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_idle got busy=%b exp 0", busy);
      end
      ticks(2);
   endtask

   task automatic test_backpressure();
      int busy_bad;
      busy_bad = 0;
      bus.async_en = 1'b1;
      ticks(3);  // after edge 2: WAIT
      hold_off = 1'b1;
      for (int e = 3; e <= 11; e++) begin
         ticks(1);
         if (e == 7) hold_off = 1'b0;
         if (busy !== 1'b1) busy_bad++;
      end
      checks++;
      if (busy_bad != 0) begin
         errors++;
         $display("FAIL bp_busy got %0d low cycles exp 0", busy_bad);
      end
      checks++;
      if (bus.async_rdy !== 1'b0) begin
         errors++;
         $display("FAIL bp_rdy_early got %b exp 0", bus.async_rdy);
      end
      ticks(1);  // after edge 12
      checks++;
      if (bus.async_rdy !== 1'b1) begin
         errors++;
         $display("FAIL bp_rdy_rise got %b exp 1", bus.async_rdy);
      end
      bus.async_en = 1'b0;
      ticks(3);
      exp_cnt = exp_cnt + 16'd1;
      checks++;
      if (txn_count !== exp_cnt || busy !== 1'b0) begin
         errors++;
         $display("FAIL bp_release got cnt=%0d busy=%b exp cnt=%0d busy=0",
                  txn_count, busy, exp_cnt);
      end
      ticks(2);
   endtask

   task automatic test_abort();
      int rdy_seen;
      rdy_seen = 0;
      bus.async_en = 1'b1;
      ticks(4);  // edges 0..3 sample 1
      bus.async_en = 1'b0;
      ticks(1);  // after edge 4: still in WAIT
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL abort_busy got %b exp 1", busy);
      end
      for (int i = 0; i < 6; i++) begin
         ticks(1);
         if (bus.async_rdy !== 1'b0) rdy_seen++;
      end
      checks++;
      if (rdy_seen != 0) begin
         errors++;
         $display("FAIL abort_rdy got %0d high cycles exp 0", rdy_seen);
      end
      checks++;
      if (busy !== 1'b0 || txn_count !== exp_cnt) begin
         errors++;
         $display("FAIL abort_idle got busy=%b cnt=%0d exp busy=0 cnt=%0d",
                  busy, txn_count, exp_cnt);
      end
   endtask

   task automatic test_timeout();
      int rdy_high;
      rdy_high = 0;
      checks++;
      if (timeout_err !== 1'b0) begin
         errors++;
         $display("FAIL to_pre_err got %b exp 0", timeout_err);
      end
      bus.async_en = 1'b1;
      for (int e = 0; e < 100; e++) begin
         clr_err = (e == 71);  // clear coincides with the setting edge
         ticks(1);
         if (bus.async_rdy === 1'b1) rdy_high++;
         if (e == 71) begin
            checks++;
            if (timeout_err !== 1'b1) begin
               errors++;
               $display("FAIL to_set_wins got %b exp 1", timeout_err);
            end
         end
      end
      clr_err = 1'b0;
      checks++;
      if (rdy_high != 64) begin
         errors++;
         $display("FAIL to_rdy_len got %0d exp 64", rdy_high);
      end
      checks++;
      if (timeout_err !== 1'b1 || txn_count !== exp_cnt || busy !== 1'b1) begin
         errors++;
         $display("FAIL to_err_state got err=%b cnt=%0d busy=%b exp err=1 cnt=%0d busy=1",
                  timeout_err, txn_count, busy, exp_cnt);
      end
      bus.async_en = 1'b0;
      ticks(3);
      checks++;
      if (busy !== 1'b0 || timeout_err !== 1'b1) begin
         errors++;
         $display("FAIL to_release got busy=%b err=%b exp busy=0 err=1", busy, timeout_err);
      end
      clr_err = 1'b1;
      ticks(1);
      clr_err = 1'b0;
      checks++;
      if (timeout_err !== 1'b0) begin
         errors++;
         $display("FAIL to_clear got %b exp 0", timeout_err);
      end
      ticks(2);
   endtask

   task automatic test_reset_mid_ack();
      bus.async_en = 1'b1;
      ticks(8);
      checks++;
      if (bus.async_rdy !== 1'b1) begin
         errors++;
         $display("FAIL rst_pre_ack got %b exp 1", bus.async_rdy);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (bus.async_rdy !== 1'b0 || busy !== 1'b0 || txn_count !== 16'd0) begin
         errors++;
         $display("FAIL rst_async got rdy=%b busy=%b cnt=%0d exp 0 0 0",
                  bus.async_rdy, busy, txn_count);
      end
      exp_cnt = 16'd0;
      ticks(2);
      rst = 1'b0;
      ticks(7);  // after edge 6 of the post-reset request
      checks++;
      if (bus.async_rdy !== 1'b0) begin
         errors++;
         $display("FAIL rst_rdy_early got %b exp 0", bus.async_rdy);
      end
      ticks(1);
      checks++;
      if (bus.async_rdy !== 1'b1) begin
         errors++;
         $display("FAIL rst_rdy_rise got %b exp 1", bus.async_rdy);
      end
      bus.async_en = 1'b0;
      ticks(3);
      exp_cnt = exp_cnt + 16'd1;
      checks++;
      if (txn_count !== exp_cnt || bus.async_rdy !== 1'b0) begin
         errors++;
         $display("FAIL rst_post_txn got cnt=%0d rdy=%b exp cnt=%0d rdy=0",
                  txn_count, bus.async_rdy, exp_cnt);
      end
      ticks(2);
   endtask

   task automatic test_wrap_zero_wait();
      logic [3:0] exp2;
      exp2 = 4'd0;
      for (int k = 0; k < 16; k++) begin
         bus2.async_en = 1'b1;
         ticks(3);  // after edge E+2
         checks++;
         if (bus2.async_rdy !== 1'b0) begin
            errors++;
            $display("FAIL wrap_rdy_early[%0d] got %b exp 0", k, bus2.async_rdy);
         end
         ticks(1);  // after edge E+3
         checks++;
         if (bus2.async_rdy !== 1'b1) begin
            errors++;
            $display("FAIL wrap_rdy_rise[%0d] got %b exp 1", k, bus2.async_rdy);
         end
         bus2.async_en = 1'b0;
         ticks(3);
         exp2 = exp2 + 4'd1;
         checks++;
         if (txn_count2 !== exp2 || bus2.async_rdy !== 1'b0) begin
            errors++;
            $display("FAIL wrap_cnt[%0d] got cnt=%0d rdy=%b exp cnt=%0d rdy=0",
                     k, txn_count2, bus2.async_rdy, exp2);
         end
      end
      checks++;
      if (txn_count2 !== 4'd0 || busy2 !== 1'b0) begin
         errors++;
         $display("FAIL wrap_final got cnt=%0d busy=%b exp cnt=0 busy=0", txn_count2, busy2);
      end
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      exp_cnt       = 16'd0;
      rst           = 1'b1;
      hold_off      = 1'b0;
      clr_err       = 1'b0;
      hold_off2     = 1'b0;
      clr_err2      = 1'b0;
      bus.async_en  = 1'b0;
      bus2.async_en = 1'b0;
      #1;
      test_reset();
      test_basic();
      test_backpressure();
      test_abort();
      test_timeout();
      test_reset_mid_ack();
      test_wrap_zero_wait();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/my_slave_rdy_responder.md
# my_slave_rdy_responder

Slave-side RTL responder for the `my_slave_interface` handshake. It consumes the master's `async_en` and produces `async_rdy` on the same interface, which the slave UVM agent drives and monitors. It synchronizes the asynchronous request, inserts a fixed number of wait states with optional back-pressure, and completes a 4-phase handshake. It also counts completed transactions and flags masters that never release the request.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth for `async_en`; minimum 2.
- `WAIT_CYCLES`, default 4: wait states between request detection and `async_rdy`; 0 is legal.
- `TIMEOUT_CYCLES`, default 64: maximum cycles `async_rdy` stays high waiting for the request to drop; minimum 1.
- `CNT_W`, default 16: width of the transaction counter.

- `clk`  in  1  single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `async_en`  in  1  request from master, asynchronous to `clk`.
- `hold_off`  in  1  back-pressure; freezes the wait-state countdown.
- `clr_err`  in  1  synchronous clear of `timeout_err`.
- `async_rdy`  out  1  acknowledge to master; registered.
- `busy`  out  1  high whenever the state is not IDLE.
- `txn_count`  out  CNT_W  count of completed handshakes; wraps.
- `timeout_err`  out  1  sticky: a request was held past `TIMEOUT_CYCLES`.

## Operation
- `async_en` passes through a `SYNC_STAGES` flop chain to produce `en_s`. Only `en_s` is used internally.
- States are IDLE, WAIT, ACK and ERR. `async_rdy` = (state == ACK), taken from a registered state.
- **IDLE**
  - `en_s`=1: go to WAIT and load `wcnt` = `WAIT_CYCLES`.
- **WAIT**
  - `en_s`=0 (abort): go to IDLE. No `async_rdy`, no count.
  - `hold_off`=1: `wcnt` frozen, stay in WAIT.
  - `wcnt`==0 and `hold_off`=0: go to ACK and clear `tcnt`.
  - Otherwise: `wcnt` decrements.
- **ACK**
  - `en_s`=0: go to IDLE and increment `txn_count`, modulo 2^CNT_W.
  - `en_s`=1 and `tcnt`==TIMEOUT_CYCLES-1: go to ERR and set `timeout_err`. `txn_count` is not incremented.
  - Otherwise: `tcnt` increments.
  - `hold_off` is ignored in ACK.
- **ERR**
  - `async_rdy`=0.
  - `en_s`=0: go to IDLE.
- `wcnt` width is $clog2(WAIT_CYCLES+1). `tcnt` width is $clog2(TIMEOUT_CYCLES).
- `timeout_err` clears on `clr_err`. If set and clear occur in the same cycle, set wins.

## Timing
- Reset values: `async_rdy`=0, `busy`=0, `txn_count`=0, `timeout_err`=0, synchronizer flops 0, state IDLE. Reset takes effect immediately and asynchronously, including mid-handshake.
- Latency is counted from edge E, the first edge that samples `async_en`=1:
  - `en_s` is high after edge E+SYNC_STAGES-1.
  - State is WAIT after edge E+SYNC_STAGES.
  - `async_rdy` rises after edge E+SYNC_STAGES+WAIT_CYCLES+1, which is E+7 with defaults.
  - Each cycle with `hold_off`=1 in WAIT adds one cycle.
- Release: if edge F is the first edge sampling `async_en`=0 while in ACK:
  - `async_rdy` falls and `txn_count` updates after edge F+SYNC_STAGES.
- `async_rdy` is high for at most `TIMEOUT_CYCLES` consecutive cycles.
- A new request is accepted only after passing through IDLE. The minimum gap is one cycle with `en_s`=0.
- `async_en` pulses shorter than one clock period may be missed. That is legal; the 4-phase protocol forbids such pulses.

## Test plan
- **Basic handshake (defaults):** `async_en` rises, first sampled at edge 0.
  - `async_rdy`=1 after edge 7.
  - Drop `async_en`, first sampled at edge 20: `async_rdy`=0 and `txn_count`=1 after edge 22.
- **Back-pressure:** as basic, with `hold_off`=1 for 5 cycles while in WAIT.
  - `async_rdy` rises after edge 12.
  - `busy`=1 throughout.
- **Abort:** `async_en` high for edges 0–3, then low.
  - `async_rdy` never rises.
  - `txn_count` unchanged; returns to IDLE with `busy`=0.
- **Timeout:** `async_en` held high for 100 cycles, `TIMEOUT_CYCLES`=64.
  - `async_rdy` high for exactly 64 cycles; `timeout_err`=1; `txn_count` unchanged.
  - After release, state is IDLE.
  - `clr_err` pulse gives `timeout_err`=0.
  - Set and `clr_err` in the same cycle leaves `timeout_err`=1.
- **Reset mid-ACK:** assert `rst` between clock edges while `async_rdy`=1.
  - `async_rdy`, `busy` and `txn_count` go to 0 immediately.
  - After reset releases with `async_en` still high, a new handshake completes normally.
- **Wrap and zero wait:** `CNT_W`=4, `WAIT_CYCLES`=0, 16 back-to-back handshakes.
  - `async_rdy` rises after edge E+3.
  - `txn_count` ends at 0 after 15.
